alu_sequencer: RTL and testbench

Sequential command front-end that drives the combinational `BreadBoard` ALU. It accepts one operation request at a time over a valid/ready command port and presents the operands and op code to the ALU. It waits a fixed settle interval, then captures `output1`/`err_code` and returns them over a valid/ready response port. It also keeps a running accumulator that later commands can use as operand A, and a count of error responses.

---
 rtl/alu_seq_pkg.sv | 11 +
 rtl/alu_settle_timer.sv | 15 +
 rtl/alu_sequencer.sv | 105 ++++++++++
 tb/tb_alu_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state, op-code and error encodings shared by the ALU sequencer.
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, RESPOND} seq_state_t;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_LAST = 4'd4;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;
endpackage

// File: rtl/alu_settle_timer.sv
// alu_settle_timer: loadable 4-bit down-counter that parks at zero.
module alu_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);
  logic [3:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (r_count != 4'd0) r_count <= r_count - 4'd1;
  assign o_zero = r_count == 4'd0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command front-end for a combinational ALU, with
// settle-delayed capture, a result accumulator and a saturating error count.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic             i_cmd_use_acc,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_result,
  output logic [1:0]       o_rsp_err,
  output logic [WIDTH-1:0] o_alu_input1,
  output logic [WIDTH-1:0] o_alu_input2,
  output logic [3:0]       o_alu_op_code,
  input  logic [31:0]      i_alu_output1,
  input  logic [1:0]       i_alu_err_code,
  output logic [31:0]      o_acc,
  output logic [7:0]       o_err_count
);
  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);
  seq_state_t r_state, w_next;
  logic r_cmd_ready;
  logic [31:0] r_rsp_result, r_acc;
  logic [1:0] r_rsp_err;
  logic [WIDTH-1:0] r_alu_in1, r_alu_in2;
  logic [3:0] r_alu_op;
  logic [7:0] r_err_count;
  logic w_accept, w_legal, w_zero, w_capture, w_err_inc;

  assign w_accept = i_cmd_valid && r_cmd_ready;
  assign w_legal = i_cmd_op <= OP_LAST;
  assign w_capture = r_state == DRIVE && w_zero;
  assign w_err_inc = (w_accept && !w_legal) || (w_capture && i_alu_err_code != 2'b00);

  alu_settle_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept && w_legal),
    .i_load_val(LOAD_VAL),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? DRIVE : RESPOND;
      DRIVE:   if (w_zero) w_next = RESPOND;
      RESPOND: if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is registered so it stays low throughout reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cmd_ready <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err <= '0;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_alu_op <= '0;
      r_acc <= '0;
      r_err_count <= '0;
    end else begin
      r_cmd_ready <= w_next == IDLE;
      if (w_accept && w_legal) begin
        r_alu_in1 <= i_cmd_use_acc ? r_acc[WIDTH-1:0] : i_cmd_a;
        r_alu_in2 <= i_cmd_b;
        r_alu_op <= i_cmd_op;
      end
      if (w_accept && !w_legal) begin
        r_rsp_result <= '0;
        r_rsp_err <= ERR_ILLEGAL;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_output1;
        r_rsp_err <= i_alu_err_code;
        if (i_alu_err_code == 2'b00) r_acc <= i_alu_output1;
      end
      if (w_err_inc && r_err_count != 8'hff) r_err_count <= r_err_count + 8'd1;
    end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_state == RESPOND;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_err = r_rsp_err;
  assign o_alu_input1 = r_alu_in1;
  assign o_alu_input2 = r_alu_in2;
  assign o_alu_op_code = r_alu_op;
  assign o_acc = r_acc;
  assign o_err_count = r_err_count;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with a stub ALU and a
// transaction-level model of accumulator and error count.
module tb_alu_sequencer;
  localparam int S = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_use_acc = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result, alu_res, acc;
  logic [1:0] rsp_err, alu_err;
  logic [15:0] alu_in1, alu_in2;
  logic [3:0] alu_op;
  logic [7:0] err_count;
  logic [31:0] m_acc = '0;
  logic [7:0] m_errs = '0;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(S), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_use_acc(cmd_use_acc),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_err(rsp_err),
    .o_alu_input1(alu_in1), .o_alu_input2(alu_in2), .o_alu_op_code(alu_op),
    .i_alu_output1(alu_res), .i_alu_err_code(alu_err),
    .o_acc(acc), .o_err_count(err_count)
  );

  // Stand-in for the combinational BreadBoard ALU.
  always_comb begin
    alu_res = '0;
    alu_err = 2'b00;
    case (alu_op)
      4'd0: alu_res = 32'(alu_in1) + 32'(alu_in2);
      4'd1: alu_res = 32'(alu_in1) - 32'(alu_in2);
      4'd2: alu_res = 32'(alu_in1) * 32'(alu_in2);
      4'd3: if (alu_in2 == 16'd0) alu_err = 2'b10; else alu_res = 32'(alu_in1 / alu_in2);
      4'd4: if (alu_in2 == 16'd0) alu_err = 2'b10; else alu_res = 32'(alu_in1 % alu_in2);
      default: alu_err = 2'b01;
    endcase
  end

  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, b,
                                 output logic [31:0] r, output logic [1:0] e);
    r = '0;
    e = 2'b00;
    if (op > 4'd4) e = 2'b11;
    else if (op >= 4'd3 && b == 16'd0) e = 2'b10;
    else if (op == 4'd0) r = 32'(a) + 32'(b);
    else if (op == 4'd1) r = 32'(a) - 32'(b);
    else if (op == 4'd2) r = 32'(a) * 32'(b);
    else if (op == 4'd3) r = 32'(a / b);
    else r = 32'(a % b);
  endfunction

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, b, input logic ua, input int hold);
    logic [15:0] ea;
    logic [31:0] er;
    logic [1:0] ee;
    logic [3:0] prev_op;
    int n, want_lat;
    ea = ua ? m_acc[15:0] : a;
    ref_op(op, ea, b, er, ee);
    want_lat = op <= 4'd4 ? S : 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready); end
    prev_op = alu_op;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(posedge clk); #1;
    cmd_valid = 1'($urandom); cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    cmd_use_acc = 1'($urandom);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (ee == 2'b00) m_acc = er;
    else if (m_errs != 8'hff) m_errs = m_errs + 8'd1;
    n_vec += 6;
    if (n !== want_lat) begin n_bad++; $display("FAIL latency op%0d: got %0d want %0d", op, n, want_lat); end
    if (rsp_result !== er) begin n_bad++; $display("FAIL rsp_result op%0d: got %0h want %0h", op, rsp_result, er); end
    if (rsp_err !== ee) begin n_bad++; $display("FAIL rsp_err op%0d: got %b want %b", op, rsp_err, ee); end
    if (acc !== m_acc) begin n_bad++; $display("FAIL acc: got %0h want %0h", acc, m_acc); end
    if (err_count !== m_errs) begin n_bad++; $display("FAIL err_count: got %0d want %0d", err_count, m_errs); end
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cmd_ready_in_rsp: got %b want 0", cmd_ready); end
    n_vec++;
    if (op <= 4'd4) begin
      if ({alu_in1, alu_in2, alu_op} !== {ea, b, op}) begin
        n_bad++; $display("FAIL alu_side: got %h/%h/%h want %h/%h/%h", alu_in1, alu_in2, alu_op, ea, b, op);
      end
    end else if (alu_op !== prev_op) begin
      n_bad++; $display("FAIL alu_op_hold: got %h want %h", alu_op, prev_op);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      n_vec++;
      if ({rsp_valid, cmd_ready, rsp_result, rsp_err} !== {1'b1, 1'b0, er, ee}) begin
        n_bad++; $display("FAIL backpressure_hold: got %b/%b/%0h/%b want 1/0/%0h/%b", rsp_valid, cmd_ready, rsp_result, rsp_err, er, ee);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_bad++; $display("FAIL after_handshake: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_err, alu_in1, alu_in2, alu_op, acc, err_count} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got ready=%b valid=%b res=%0h acc=%0h errs=%0d want all 0", cmd_ready, rsp_valid, rsp_result, acc, err_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_multiply();   run_cmd(4'd2, 16'd11, 16'd15, 1'b0, 0); endtask
  task automatic test_div_zero();   run_cmd(4'd3, 16'd11, 16'd0, 1'b0, 0); endtask
  task automatic test_illegal();    run_cmd(4'd9, 16'd7, 16'd8, 1'b0, 0); endtask
  task automatic test_acc_operand(); run_cmd(4'd2, 16'hdead, 16'd2, 1'b1, 0); endtask
  task automatic test_backpressure(); run_cmd(4'd0, 16'd100, 16'd23, 1'b0, 5); endtask

  task automatic test_back_to_back();
    int accepts = 0;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'd1; cmd_b = 16'd2; cmd_use_acc = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_valid && cmd_ready) accepts++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    m_acc = 32'd3;
    n_vec += 2;
    if (accepts !== 40 / (S + 2)) begin n_bad++; $display("FAIL throughput: got %0d want %0d", accepts, 40 / (S + 2)); end
    if (acc !== m_acc) begin n_bad++; $display("FAIL throughput_acc: got %0h want %0h", acc, m_acc); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [15:0] b;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom % 5 == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      b = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom);
      run_cmd(op, 16'($urandom), b, 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    while (!cmd_ready) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 16'd7; cmd_b = 16'd9; cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_acc = '0; m_errs = '0;
    n_vec++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_err, alu_in1, alu_in2, alu_op, acc, err_count} !== '0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got ready=%b valid=%b in1=%0h op=%0h acc=%0h want all 0", cmd_ready, rsp_valid, alu_in1, alu_op, acc);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ready: got %b want 1", cmd_ready); end
    repeat (5) begin
      n_vec++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_no_rsp: got %b want 0", rsp_valid); end
      @(posedge clk); #1;
    end
    run_cmd(4'd0, 16'd5, 16'd6, 1'b1, 0);
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) run_cmd(4'd15, 16'd0, 16'd0, 1'b0, 0);
    n_vec++;
    if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_saturate: got %0d want 255", err_count); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_div_zero();
    test_illegal();
    test_acc_operand();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_err_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
